spi_slave_xfer: RTL and testbench

//  Full-duplex SPI slave: receives MOSI words and transmits MISO words, oversampled in the system clock domain.

---
 rtl/spi_slave_xfer.sv | 187 ++++++++++++++++++
 tb/tb_spi_slave_xfer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_xfer.sv
// Full-duplex SPI slave with a one-word TX buffer.
// All SPI pins are oversampled in the clk domain.
module spi_slave_xfer #(
    parameter int unsigned DATA_W      = 8,
    parameter bit          CPOL        = 1'b0,
    parameter bit          CPHA        = 1'b0,
    parameter bit          MSB_FIRST   = 1'b1,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_clk,
    input  logic              spi_ss,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              rx_abort,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_underrun
);
    localparam int unsigned CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic {ST_IDLE, ST_ACTIVE} state_e;

    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] ss_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic sclk_s, ss_s, mosi_s;
    logic sclk_prev_q, ss_prev_q;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              rx_abort_q, rx_abort_d;
    logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_W-1:0] tx_buf_q, tx_buf_d;
    logic              tx_full_q, tx_full_d;
    logic              underrun_q, underrun_d;

    logic sclk_rise, sclk_fall, lead_edge, trail_edge;
    logic sample_edge, shift_edge, ss_fall, ss_rise;
    logic load, tx_wr;
    logic [DATA_W-1:0] rx_next, tx_next;

    // Synchronisers are not reset so a reset mid-frame keeps the
    // true pin level and cannot fabricate an SS fall.
    always_ff @(posedge clk) begin
        sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_clk};
        ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], spi_ss};
        mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    end

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign ss_s   = ss_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    // ss_prev resets low: a new frame needs SS seen high first.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_prev_q <= CPOL;
            ss_prev_q   <= 1'b0;
        end else begin
            sclk_prev_q <= sclk_s;
            ss_prev_q   <= ss_s;
        end
    end

    assign sclk_rise   = sclk_s & ~sclk_prev_q;
    assign sclk_fall   = ~sclk_s & sclk_prev_q;
    assign lead_edge   = CPOL ? sclk_fall : sclk_rise;
    assign trail_edge  = CPOL ? sclk_rise : sclk_fall;
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge : trail_edge;
    assign ss_fall     = ~ss_s & ss_prev_q;
    assign ss_rise     = ss_s & ~ss_prev_q;

    assign rx_next = MSB_FIRST ? {rx_shift_q[DATA_W-2:0], mosi_s}
                               : {mosi_s, rx_shift_q[DATA_W-1:1]};
    assign tx_next = MSB_FIRST ? {tx_shift_q[DATA_W-2:0], 1'b0}
                               : {1'b0, tx_shift_q[DATA_W-1:1]};

    assign tx_ready = ~tx_full_q;
    assign tx_wr    = tx_valid & ~tx_full_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rx_abort_d = 1'b0;
        tx_shift_d = tx_shift_q;
        tx_buf_d   = tx_buf_q;
        tx_full_d  = tx_full_q;
        underrun_d = 1'b0;
        load       = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (ss_fall) begin
                    state_d = ST_ACTIVE;
                    cnt_d   = '0;
                    load    = ~CPHA;
                end
            end
            ST_ACTIVE: begin
                if (ss_rise) begin
                    state_d    = ST_IDLE;
                    cnt_d      = '0;
                    rx_shift_d = '0;
                    rx_abort_d = (cnt_q != '0);
                end else begin
                    if (sample_edge) begin
                        rx_shift_d = rx_next;
                        if (cnt_q == CNT_LAST) begin
                            rx_data_d  = rx_next;
                            rx_valid_d = 1'b1;
                            cnt_d      = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                    if (shift_edge) begin
                        if (cnt_q == '0) load = 1'b1;
                        else tx_shift_d = tx_next;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A same-cycle write is invisible to the load.
        if (load) begin
            if (tx_full_q) begin
                tx_shift_d = tx_buf_q;
                tx_full_d  = 1'b0;
            end else begin
                tx_shift_d = '0;
                underrun_d = 1'b1;
            end
        end
        if (tx_wr) begin
            tx_buf_d  = tx_data;
            tx_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_abort_q <= 1'b0;
            tx_shift_q <= '0;
            tx_buf_q   <= '0;
            tx_full_q  <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_abort_q <= rx_abort_d;
            tx_shift_q <= tx_shift_d;
            tx_buf_q   <= tx_buf_d;
            tx_full_q  <= tx_full_d;
            underrun_q <= underrun_d;
        end
    end

    assign miso_oe     = (state_q == ST_ACTIVE);
    assign miso        = miso_oe & (MSB_FIRST ? tx_shift_q[DATA_W-1]
                                              : tx_shift_q[0]);
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign rx_abort    = rx_abort_q;
    assign tx_underrun = underrun_q;

endmodule

// File: tb/tb_spi_slave_xfer.sv
// Bench for spi_slave_xfer: 8-bit mode 0 MSB-first and
// 16-bit mode 3 LSB-first instances driven by a pin-level master.
module tb_spi_slave_xfer;
    localparam int HALF = 80;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       sclk_a = 1'b0, ss_a = 1'b1, mosi_a = 1'b0;
    logic       miso_a, oe_a, rxv_a, rxab_a, txr_a, ur_a;
    logic [7:0] rxd_a;
    logic [7:0] txd_a = '0;
    logic       txv_a = 1'b0;

    logic        sclk_b = 1'b1, ss_b = 1'b1, mosi_b = 1'b0;
    logic        miso_b, oe_b, rxv_b, rxab_b, txr_b, ur_b;
    logic [15:0] rxd_b;
    logic [15:0] txd_b = '0;
    logic        txv_b = 1'b0;

    int n_vec = 0, n_err = 0;
    int nrx_a = 0, nur_a = 0, nab_a = 0;
    int nrx_b = 0, nur_b = 0, nab_b = 0;
    logic [15:0] exp_a[$];
    logic [15:0] exp_b[$];

    always #5 clk = ~clk;

    spi_slave_xfer #(.DATA_W(8), .CPOL(1'b0), .CPHA(1'b0),
        .MSB_FIRST(1'b1), .SYNC_STAGES(2)) u_a (
        .clk(clk), .rst(rst), .spi_clk(sclk_a), .spi_ss(ss_a),
        .mosi(mosi_a), .miso(miso_a), .miso_oe(oe_a),
        .rx_data(rxd_a), .rx_valid(rxv_a), .rx_abort(rxab_a),
        .tx_data(txd_a), .tx_valid(txv_a), .tx_ready(txr_a),
        .tx_underrun(ur_a));

    spi_slave_xfer #(.DATA_W(16), .CPOL(1'b1), .CPHA(1'b1),
        .MSB_FIRST(1'b0), .SYNC_STAGES(2)) u_b (
        .clk(clk), .rst(rst), .spi_clk(sclk_b), .spi_ss(ss_b),
        .mosi(mosi_b), .miso(miso_b), .miso_oe(oe_b),
        .rx_data(rxd_b), .rx_valid(rxv_b), .rx_abort(rxab_b),
        .tx_data(txd_b), .tx_valid(txv_b), .tx_ready(txr_b),
        .tx_underrun(ur_b));

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rxv_a) begin
            nrx_a++;
            if (exp_a.size() == 0) chk("rxA_extra", exp_a.size(), 1);
            else chk("rxA_data", rxd_a, exp_a.pop_front());
        end
        if (ur_a) nur_a++;
        if (rxab_a) nab_a++;
        if (rxv_b) begin
            nrx_b++;
            if (exp_b.size() == 0) chk("rxB_extra", exp_b.size(), 1);
            else chk("rxB_data", rxd_b, exp_b.pop_front());
        end
        if (ur_b) nur_b++;
        if (rxab_b) nab_b++;
    end

    task automatic bits_a(input logic [7:0] mo, input int hi,
                          input int lo, inout logic [7:0] mi);
        for (int i = hi; i >= lo; i--) begin
            mosi_a = mo[i];
            #(HALF);
            sclk_a = 1'b1;
            mi[i] = miso_a;
            #(HALF);
            sclk_a = 1'b0;
        end
    endtask

    task automatic word_a(input logic [7:0] mo, input logic [7:0] emi,
                          input string tag);
        logic [7:0] mi = '0;
        exp_a.push_back(16'(mo));
        bits_a(mo, 7, 0, mi);
        chk(tag, mi, emi);
    endtask

    task automatic word_b(input logic [15:0] mo, input logic [15:0] emi,
                          input string tag);
        logic [15:0] mi = '0;
        exp_b.push_back(mo);
        for (int i = 0; i < 16; i++) begin
            sclk_b = 1'b0;
            mosi_b = mo[i];
            #(HALF);
            sclk_b = 1'b1;
            mi[i] = miso_b;
            #(HALF);
        end
        chk(tag, mi, emi);
    endtask

    task automatic tx_put_a(input logic [7:0] d);
        int n = 0;
        @(negedge clk);
        while (!txr_a && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!txr_a) chk("txA_timeout", txr_a, 1);
        txd_a = d;
        txv_a = 1'b1;
        @(negedge clk);
        txv_a = 1'b0;
    endtask

    task automatic tx_put_b(input logic [15:0] d);
        int n = 0;
        @(negedge clk);
        while (!txr_b && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!txr_b) chk("txB_timeout", txr_b, 1);
        txd_b = d;
        txv_b = 1'b1;
        @(negedge clk);
        txv_b = 1'b0;
    endtask

    task automatic ss_lo_a();
        ss_a = 1'b0;
        #(HALF);
    endtask

    task automatic ss_hi_a();
        #(HALF);
        ss_a = 1'b1;
        #(2 * HALF);
    endtask

    task automatic ss_lo_b();
        ss_b = 1'b0;
        #(HALF);
    endtask

    task automatic ss_hi_b();
        #(HALF);
        ss_b = 1'b1;
        #(2 * HALF);
    endtask

    task automatic pulse_rst();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic chk_rst_a(input string t);
        chk({t, "_rxd"}, rxd_a, 0);
        chk({t, "_rxv"}, rxv_a, 0);
        chk({t, "_abort"}, rxab_a, 0);
        chk({t, "_miso"}, miso_a, 0);
        chk({t, "_oe"}, oe_a, 0);
        chk({t, "_txrdy"}, txr_a, 1);
        chk({t, "_ur"}, ur_a, 0);
    endtask

    initial begin
        logic [7:0] mi;
        int c_rx, c_ur, c_ab;
        mi = '0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk_rst_a("rst");
        chk("rst_oeB", oe_b, 0);
        chk("rst_txrdyB", txr_b, 1);

        // 1: single word, mode 0
        tx_put_a(8'h3C);
        c_rx = nrx_a; c_ab = nab_a;
        ss_lo_a();
        chk("t1_oe", oe_a, 1);
        word_a(8'hA5, 8'h3C, "t1_miso");
        ss_hi_a();
        chk("t1_nrx", nrx_a - c_rx, 1);
        chk("t1_rxd", rxd_a, 8'hA5);
        chk("t1_nabort", nab_a - c_ab, 0);
        chk("t1_oe_off", oe_a, 0);
        pulse_rst();

        // 2: back-to-back words with TX refills
        tx_put_a(8'h11);
        c_rx = nrx_a; c_ur = nur_a;
        ss_lo_a();
        fork
            begin
                word_a(8'h01, 8'h11, "t2_miso0");
                word_a(8'h80, 8'h22, "t2_miso1");
                word_a(8'hFF, 8'h33, "t2_miso2");
            end
            begin
                tx_put_a(8'h22);
                tx_put_a(8'h33);
                tx_put_a(8'h44);
            end
        join
        ss_hi_a();
        chk("t2_nrx", nrx_a - c_rx, 3);
        chk("t2_nur", nur_a - c_ur, 0);
        pulse_rst();

        // 3: 16-bit mode 3 LSB first
        tx_put_b(16'hBEEF);
        c_rx = nrx_b; c_ur = nur_b;
        ss_lo_b();
        word_b(16'h1234, 16'hBEEF, "t3_miso");
        ss_hi_b();
        chk("t3_nrx", nrx_b - c_rx, 1);
        chk("t3_rxd", rxd_b, 16'h1234);
        chk("t3_nur", nur_b - c_ur, 0);

        // 4: empty TX buffer at first load
        c_ur = nur_b;
        ss_lo_b();
        word_b(16'hA55A, 16'h0000, "t4_miso");
        ss_hi_b();
        chk("t4_nur", nur_b - c_ur, 1);
        chk("t4_rxd", rxd_b, 16'hA55A);

        // 5: abort after 5 bits, then a clean frame
        c_rx = nrx_a; c_ab = nab_a;
        ss_lo_a();
        bits_a(8'hB7, 7, 3, mi);
        ss_hi_a();
        chk("t5_nabort", nab_a - c_ab, 1);
        chk("t5_nrx", nrx_a - c_rx, 0);
        chk("t5_oe", oe_a, 0);
        ss_lo_a();
        word_a(8'h5A, 8'h00, "t5_miso");
        ss_hi_a();
        chk("t5_rxd", rxd_a, 8'h5A);

        // 6: reset mid-word with SS held low
        c_rx = nrx_a; c_ab = nab_a;
        ss_lo_a();
        bits_a(8'hC3, 7, 4, mi);
        pulse_rst();
        chk_rst_a("t6");
        bits_a(8'hC3, 3, 0, mi);
        ss_hi_a();
        chk("t6_nrx", nrx_a - c_rx, 0);
        chk("t6_nabort", nab_a - c_ab, 0);
        ss_lo_a();
        word_a(8'h96, 8'h00, "t6_miso");
        ss_hi_a();
        chk("t6_rxd", rxd_a, 8'h96);
        chk("t6_nrx2", nrx_a - c_rx, 1);
        chk("q_leftA", exp_a.size(), 0);
        chk("q_leftB", exp_b.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
